// File: rtl/sram1rw_arbiter.sv
// sram1rw_arbiter: shares one single-port 128x8 SRAM macro between two
// requesters. Round-robin grant, one access per cycle, 1-cycle response.
// Optional power-up zero fill of the macro: define SRAM1RW_ARBITER_INIT_EN.
module sram1rw_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    logic   r_rr_ptr;     // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic   r_rsp_v;
    logic   r_rsp_port;
    logic   r_rsp_rd;
    logic   r_init_done;

    logic   w_run;
    logic   w_init;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_xfer;
    logic   w_sel_write;

`ifdef SRAM1RW_ARBITER_INIT_EN
    logic [ADDR_W-1:0] r_init_addr;
    assign w_init = ~reset & (r_state == ST_INIT);
`else
    assign w_init = 1'b0;
`endif

    // Requests are only served in RUN and never while reset is asserted.
    assign w_run  = ~reset & (r_state == ST_RUN);
    assign w_gnt0 = w_run & p0_req_valid & (~p1_req_valid | ~r_rr_ptr);
    assign w_gnt1 = w_run & p1_req_valid & (~p0_req_valid |  r_rr_ptr);
    assign w_xfer = w_gnt0 | w_gnt1;
    assign w_sel_write = w_gnt1 ? p1_req_write : p0_req_write;

    assign p0_req_ready = w_gnt0;
    assign p1_req_ready = w_gnt1;

    // Responses are masked during reset so an in-flight one is dropped at once.
    assign p0_resp_valid = ~reset & r_rsp_v & ~r_rsp_port;
    assign p1_resp_valid = ~reset & r_rsp_v &  r_rsp_port;
    assign p0_resp_rdata = (p0_resp_valid & r_rsp_rd) ? sram_o : {DATA_W{1'b0}};
    assign p1_resp_rdata = (p1_resp_valid & r_rsp_rd) ? sram_o : {DATA_W{1'b0}};
    assign init_done     = r_init_done;

    // Macro drive: zero-fill write in INIT, granted request in RUN, idle otherwise.
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_oeb = 1'b1;
        sram_a   = {ADDR_W{1'b0}};
        sram_i   = {DATA_W{1'b0}};
        if (reset) begin
            sram_csb = 1'b1;
        end else if (w_init) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
`ifdef SRAM1RW_ARBITER_INIT_EN
            sram_a   = r_init_addr;
`endif
        end else if (w_gnt0) begin
            sram_csb = 1'b0;
            sram_web = ~p0_req_write;
            sram_oeb = p0_req_write;
            sram_a   = p0_req_addr;
            sram_i   = p0_req_wdata;
        end else if (w_gnt1) begin
            sram_csb = 1'b0;
            sram_web = ~p1_req_write;
            sram_oeb = p1_req_write;
            sram_a   = p1_req_addr;
            sram_i   = p1_req_wdata;
        end else begin
            sram_csb = 1'b1;
        end
    end

    // Control FSM: init sequencing, round-robin pointer and response pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef SRAM1RW_ARBITER_INIT_EN
            r_state     <= ST_INIT;
            r_init_addr <= {ADDR_W{1'b0}};
            r_init_done <= 1'b0;
`else
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
`endif
            r_rr_ptr    <= 1'b0;
            r_rsp_v     <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else begin
            r_rsp_v <= w_xfer;
            if (w_xfer) begin
                r_rsp_port <= w_gnt1;
                r_rsp_rd   <= ~w_sel_write;
                // point at the port that was not just served
                r_rr_ptr   <= w_gnt0;
            end
            case (r_state)
                ST_INIT: begin
`ifdef SRAM1RW_ARBITER_INIT_EN
                    r_init_addr <= r_init_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_init_addr == {ADDR_W{1'b1}}) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
`else
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
`endif
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
